// File: rtl/divisor8x8_if.sv
// Request/result bundle for the 8-bit repeated-subtraction divider.
// The requester drives START/A/B; the divider returns quotient, remainder and flags.
interface divisor8x8_if;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Quociente;
    logic [7:0] Resto;
    logic       DivZero;
    logic       Pronto;

    modport master (
        output START, A, B,
        input  Quociente, Resto, DivZero, Pronto
    );

    modport slave (
        input  START, A, B,
        output Quociente, Resto, DivZero, Pronto
    );
endinterface

// File: rtl/divisor8x8.sv
// Sequential 8-bit unsigned divider: one divisor subtraction per clock.
// A zero divisor saturates the quotient to 0xFF and raises DivZero.
module divisor8x8 (
    input logic         CLOCK,
    input logic         RESET,
    divisor8x8_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q;
    logic [7:0] rem_q;
    logic [7:0] quo_q;
    logic [7:0] div_q;
    logic       div_zero_q;
    logic       pronto_q;

    logic [8:0] diff;
    logic       borrow;

    // The borrow out of the 9-bit subtraction doubles as the rem < div comparison.
    assign diff   = {1'b0, rem_q} - {1'b0, div_q};
    assign borrow = diff[8];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= StIdle;
            rem_q      <= 8'h00;
            quo_q      <= 8'h00;
            div_q      <= 8'h00;
            div_zero_q <= 1'b0;
            pronto_q   <= 1'b0;
        end else if (bus.START) begin
            rem_q <= bus.A;
            div_q <= bus.B;
            if (bus.B == 8'h00) begin
                quo_q      <= 8'hFF;
                div_zero_q <= 1'b1;
                pronto_q   <= 1'b1;
                state_q    <= StDone;
            end else begin
                quo_q      <= 8'h00;
                div_zero_q <= 1'b0;
                pronto_q   <= 1'b0;
                state_q    <= StRun;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!borrow) begin
                        rem_q <= diff[7:0];
                        quo_q <= quo_q + 8'd1;
                    end else begin
                        pronto_q <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StIdle, StDone: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.Quociente = quo_q;
    assign bus.Resto     = rem_q;
    assign bus.DivZero   = div_zero_q;
    assign bus.Pronto    = pronto_q;

endmodule

// File: tb/tb_divisor8x8.sv
// Directed plus random checks of divisor8x8 against a plain-arithmetic model
// (quotient, remainder, and completion latency of quotient+1 edges).
module tb_divisor8x8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    divisor8x8_if bus ();

    divisor8x8 dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for Pronto, counting edges; optionally scrambles A/B each cycle.
    task automatic wait_done(output int n, input bit scramble);
        n = 0;
        while (bus.Pronto !== 1'b1 && n < 400) begin
            if (scramble) begin
                bus.A = 8'($urandom);
                bus.B = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Pulses START for one edge; returns at the negedge after the START edge.
    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input bit scramble);
        int n;
        int exp_q;
        int exp_r;
        int exp_lat;
        if (b == 0) begin
            exp_q   = 255;
            exp_r   = a;
            exp_lat = 0;
        end else begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_lat = exp_q + 1;
        end
        pulse_start(a, b);
        if (b != 0) check({tag, " pronto_low_after_start"}, 32'(bus.Pronto), 0);
        wait_done(n, scramble);
        check({tag, " latency"}, n, exp_lat);
        check({tag, " quociente"}, 32'(bus.Quociente), exp_q);
        check({tag, " resto"}, 32'(bus.Resto), exp_r);
        check({tag, " divzero"}, 32'(bus.DivZero), (b == 0) ? 1 : 0);
        @(negedge clk);
        check({tag, " hold_quociente"}, 32'(bus.Quociente), exp_q);
        check({tag, " hold_pronto"}, 32'(bus.Pronto), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " quociente0"}, 32'(bus.Quociente), 0);
        check({tag, " resto0"}, 32'(bus.Resto), 0);
        check({tag, " divzero0"}, 32'(bus.DivZero), 0);
        check({tag, " pronto0"}, 32'(bus.Pronto), 0);
    endtask

    initial begin
        int n;
        logic [7:0] ra;
        logic [7:0] rb;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.START = 1'b0;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        run_one("basic_100_7", 8'd100, 8'd7, 1'b0);
        run_one("small_5_9", 8'd5, 8'd9, 1'b0);
        run_one("exact_9_9", 8'd9, 8'd9, 1'b0);
        run_one("divzero_77_0", 8'd77, 8'd0, 1'b0);
        pulse_start(8'd10, 8'd3);
        check("divzero_cleared", 32'(bus.DivZero), 0);
        wait_done(n, 1'b0);
        check("after_divzero_quo", 32'(bus.Quociente), 3);
        run_one("worst_255_1", 8'd255, 8'd1, 1'b1);

        // Reset in the middle of a long division.
        pulse_start(8'd200, 8'd2);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_reset");
        repeat (3) @(negedge clk);
        check_zero("mid_reset_idle");

        // Restart in the middle; Pronto must never rise before the new result.
        pulse_start(8'd200, 8'd2);
        for (int i = 0; i < 9; i++) begin
            check("restart_no_pronto", 32'(bus.Pronto), 0);
            @(negedge clk);
        end
        pulse_start(8'd10, 8'd3);
        wait_done(n, 1'b0);
        check("restart_latency", n, 4);
        check("restart_quo", 32'(bus.Quociente), 3);
        check("restart_rem", 32'(bus.Resto), 1);

        // Reset and START together.
        rst       = 1'b1;
        bus.START = 1'b1;
        bus.A     = 8'd50;
        bus.B     = 8'd0;
        @(negedge clk);
        rst       = 1'b0;
        bus.START = 1'b0;
        check_zero("reset_with_start");

        // START held five cycles: no progress until it drops.
        bus.A     = 8'd50;
        bus.B     = 8'd5;
        bus.START = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("held_start_no_pronto", 32'(bus.Pronto), 0);
            check("held_start_quo", 32'(bus.Quociente), 0);
        end
        bus.START = 1'b0;
        wait_done(n, 1'b0);
        check("held_start_latency", n, 11);
        check("held_start_result", 32'(bus.Quociente), 10);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom_range(0, 255));
            run_one($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
